// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared widths, state and addressing-mode encodings for the LDM/STM sequencer
//
// Purpose : common definitions imported by ldm_stm_sequencer and reg_list_scan.
// Contents: WORD_SIZE / NUM_REGS / ADDR_WIDTH defaults,
//           seq_state_t (sequencer FSM states),
//           am_mode_t   (block addressing mode, encoded as {P,U}).
package arm_pkg;

  localparam int WORD_SIZE  = 32;
  localparam int NUM_REGS   = 16;
  localparam int ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_WB   = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

  // {P,U}: P = adjust before access, U = ascending from base.
  typedef enum logic [1:0] {
    MODE_DA = 2'b00,
    MODE_IA = 2'b01,
    MODE_DB = 2'b10,
    MODE_IB = 2'b11
  } am_mode_t;

endpackage

// File: rtl/reg_list_scan.sv
// rtl/reg_list_scan.sv - lowest-set-bit finder plus popcount of the remaining mask
//
// Purpose : purely combinational helper for the sequencer. Given a register
//           mask it reports the lowest set index, the mask with that bit
//           cleared, and how many bits are still set after clearing it.
// Ports   : mask       in  NUM_REGS    register mask to scan
//           any        out 1           mask has at least one bit set
//           idx        out ADDR_WIDTH  index of the lowest set bit (0 if none)
//           rest       out NUM_REGS    mask with the lowest set bit cleared
//           rest_count out CNT_W       popcount(rest)
module reg_list_scan #(
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_W      = $clog2(NUM_REGS + 1)
) (
  input  logic [NUM_REGS-1:0]   mask,
  output logic                  any,
  output logic [ADDR_WIDTH-1:0] idx,
  output logic [NUM_REGS-1:0]   rest,
  output logic [CNT_W-1:0]      rest_count
);

  logic [CNT_W-1:0] cnt;

  assign any = |mask;

  // Clearing the lowest set bit: x & (x - 1).
  assign rest = mask & (mask - NUM_REGS'(1));

  // Walk from the top down so the last hit is the lowest index.
  always_comb begin
    idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = ADDR_WIDTH'(i);
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt = cnt + CNT_W'(rest[i]);
    end
  end

  assign rest_count = cnt;

endmodule

// File: rtl/ldm_stm_sequencer.sv
// rtl/ldm_stm_sequencer.sv - ARM-style LDM/STM block transfer sequencer
//
// Purpose : walks a register list in ascending order, issuing one memory
//           word transfer per listed register, with optional base writeback.
// Config  : SEQ_BASE_WRITEBACK_EN - when defined, the WB state updates the
//           base register; when undefined, wb is ignored and XFER goes
//           straight to DONE.
// Ports   : clk, reset (async, active low)
//           start/is_load/mode/wb/base_reg/base_val/reg_list  request, latched in IDLE
//           busy, done                                        status
//           mem_req/mem_we/mem_addr/mem_wdata                 memory request
//           mem_rdata/mem_ready                               memory response
//           rf_rd_addr/rf_rd_data                             register read port (store data)
//           rf_we/rf_wr_addr/rf_wr_data                       register write port (load data, writeback)
module ldm_stm_sequencer #(
  parameter int WORD_SIZE  = arm_pkg::WORD_SIZE,
  parameter int NUM_REGS   = arm_pkg::NUM_REGS,
  parameter int ADDR_WIDTH = arm_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_load,
  input  logic [1:0]            mode,
  input  logic                  wb,
  input  logic [ADDR_WIDTH-1:0] base_reg,
  input  logic [WORD_SIZE-1:0]  base_val,
  input  logic [NUM_REGS-1:0]   reg_list,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [WORD_SIZE-1:0]  mem_addr,
  output logic [WORD_SIZE-1:0]  mem_wdata,
  input  logic [WORD_SIZE-1:0]  mem_rdata,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr,
  input  logic [WORD_SIZE-1:0]  rf_rd_data,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_wr_addr,
  output logic [WORD_SIZE-1:0]  rf_wr_data
);

  import arm_pkg::*;

  localparam int CNT_W = $clog2(NUM_REGS + 1);

  seq_state_t state;

  logic                  is_load_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  mem_we_q;
  logic [NUM_REGS-1:0]   mask_q;
  logic [WORD_SIZE-1:0]  mem_addr_q;

  logic                  wb_do_q;
  logic [ADDR_WIDTH-1:0] base_reg_q;
  logic [WORD_SIZE-1:0]  wb_data_q;
  logic                  wb_state;

  logic [NUM_REGS-1:0]   scan_mask;
  logic                  scan_any;
  logic [ADDR_WIDTH-1:0] scan_idx;
  logic [NUM_REGS-1:0]   scan_rest;
  logic [CNT_W-1:0]      scan_rest_cnt;

  logic [CNT_W-1:0]      list_cnt;
  logic [WORD_SIZE-1:0]  span;
  logic [WORD_SIZE-1:0]  start_addr;

  logic                  xfer_hs;
  logic                  store_xfer;
  logic                  load_hs;

  // One scanner serves both jobs: in IDLE it counts the incoming list,
  // in XFER it picks the current register out of the remaining mask.
  assign scan_mask = (state == ST_XFER) ? mask_q : reg_list;

  reg_list_scan #(
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_W      (CNT_W)
  ) u_scan (
    .mask       (scan_mask),
    .any        (scan_any),
    .idx        (scan_idx),
    .rest       (scan_rest),
    .rest_count (scan_rest_cnt)
  );

  assign list_cnt = scan_rest_cnt + CNT_W'(scan_any);
  assign span     = WORD_SIZE'(list_cnt) << 2;

  // Lowest address touched; the walk always ascends from here.
  always_comb begin
    start_addr = base_val;
    case (am_mode_t'(mode))
      MODE_IA: start_addr = base_val;
      MODE_IB: start_addr = base_val + WORD_SIZE'(4);
      MODE_DA: start_addr = base_val - span + WORD_SIZE'(4);
      MODE_DB: start_addr = base_val - span;
      default: start_addr = base_val;
    endcase
  end

  assign xfer_hs    = (state == ST_XFER) && mem_ready;
  assign store_xfer = (state == ST_XFER) && !is_load_q;
  assign load_hs    = xfer_hs && is_load_q;

`ifdef SEQ_BASE_WRITEBACK_EN
  // Writeback is decided at start: skipped for an empty list, and for a
  // load that also fetches the base register so the loaded value survives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_do_q    <= 1'b0;
      base_reg_q <= '0;
      wb_data_q  <= '0;
    end else if (state == ST_IDLE && start) begin
      wb_do_q    <= wb && scan_any && !(is_load && reg_list[base_reg]);
      base_reg_q <= base_reg;
      wb_data_q  <= mode[0] ? (base_val + span) : (base_val - span);
    end
  end

  assign wb_state = (state == ST_WB);
`else
  logic unused_wb;

  assign wb_do_q    = 1'b0;
  assign base_reg_q = '0;
  assign wb_data_q  = '0;
  assign wb_state   = 1'b0;
  assign unused_wb  = ^{wb, base_reg};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      is_load_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_we_q   <= 1'b0;
      mask_q     <= '0;
      mem_addr_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            is_load_q <= is_load;
            mask_q    <= reg_list;
            busy_q    <= 1'b1;
            if (scan_any) begin
              state      <= ST_XFER;
              mem_addr_q <= start_addr;
              mem_we_q   <= !is_load;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_XFER: begin
          if (mem_ready) begin
            mask_q     <= scan_rest;
            mem_addr_q <= mem_addr_q + WORD_SIZE'(4);
            if (scan_rest == '0) begin
              mem_addr_q <= '0;
              mem_we_q   <= 1'b0;
              state      <= wb_do_q ? ST_WB : ST_DONE;
            end
          end
        end
        ST_WB: begin
          state <= ST_DONE;
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign mem_req    = (state == ST_XFER);
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign rf_rd_addr = store_xfer ? scan_idx : '0;
  assign mem_wdata  = store_xfer ? rf_rd_data : '0;
  assign rf_we      = load_hs || wb_state;
  assign rf_wr_addr = wb_state ? base_reg_q : (load_hs ? scan_idx : '0);
  assign rf_wr_data = wb_state ? wb_data_q : (load_hs ? mem_rdata : '0);

endmodule
